// File: rtl/seq_div_16_8.sv
// Sequential unsigned restoring divider, N / D -> Q, R, one quotient bit per clock, valid/ready on both sides.
// Optional reconstruction self-check (Q*D+R vs N) enabled by defining DIV_EXACT_CHECK_EN.
module seq_div_16_8 #(
  parameter int DIVIDEND_W = 16,
  parameter int DIVISOR_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] IN1,
  input  logic [DIVISOR_W-1:0]  IN2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] Q,
  output logic [DIVISOR_W-1:0]  R,
`ifdef DIV_EXACT_CHECK_EN
  output logic                  check_err,
`endif
  output logic                  div_by_zero
);

  // state | meaning
  // IDLE  | waiting for an operand pair (in_ready once out of reset)
  // CALC  | one restoring step per cycle, DIVIDEND_W steps
  // DONE  | result presented, held until out_ready
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int CNT_W = $clog2(DIVIDEND_W);

  state_t state, next_state;

  logic                  accept;
  logic                  iterate;
  logic [CNT_W-1:0]      cnt;
  logic [DIVISOR_W:0]    rem;
  logic [DIVIDEND_W-1:0] dvd;
  logic [DIVISOR_W-1:0]  dsr;

  logic [DIVISOR_W+1:0]  shifted;
  logic [DIVISOR_W+1:0]  diff;
  logic                  qbit;
  logic [DIVISOR_W:0]    rem_next;
  logic [DIVIDEND_W-1:0] dvd_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    iterate    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept     = 1'b1;
          next_state = (IN2 == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        iterate = 1'b1;
        if (cnt == '0) next_state = DONE;
      end
      DONE: begin
        if (out_valid && out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Remainder stays below D, so shifted never exceeds 2*255+1 and the top diff bit is a clean borrow.
  always_comb begin
    shifted  = {rem, dvd[DIVIDEND_W-1]};
    diff     = shifted - {2'b00, dsr};
    qbit     = ~diff[DIVISOR_W+1];
    rem_next = qbit ? diff[DIVISOR_W:0] : shifted[DIVISOR_W:0];
    dvd_next = {dvd[DIVIDEND_W-2:0], qbit};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      Q           <= '0;
      R           <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      rem         <= '0;
      dvd         <= '0;
      dsr         <= '0;
    end else begin
      in_ready  <= (next_state == IDLE);
      out_valid <= (next_state == DONE);
      if (accept) begin
        dvd <= IN1;
        dsr <= IN2;
        rem <= '0;
        cnt <= CNT_W'(DIVIDEND_W - 1);
        if (IN2 == '0) begin
          Q           <= '1;
          R           <= '0;
          div_by_zero <= 1'b1;
        end
      end else if (iterate) begin
        rem <= rem_next;
        dvd <= dvd_next;
        if (cnt != '0) cnt <= cnt - 1'b1;
        if (cnt == '0) begin
          Q           <= dvd_next;
          R           <= rem_next[DIVISOR_W-1:0];
          div_by_zero <= 1'b0;
        end
      end
    end
  end

`ifdef DIV_EXACT_CHECK_EN
  localparam int P_W = DIVIDEND_W + DIVISOR_W;

  logic [DIVIDEND_W-1:0] n_lat;
  logic [P_W-1:0]        recon;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         n_lat <= '0;
    else if (accept) n_lat <= IN1;
  end

  always_comb begin
    recon     = P_W'(Q) * P_W'(dsr) + P_W'(R);
    check_err = out_valid && !div_by_zero && (recon != P_W'(n_lat));
  end
`endif

endmodule

// File: tb/tb_seq_div_16_8.sv
// Self-checking bench for seq_div_16_8: directed cases, backpressure, mid-calculation reset, random pairs.
// Expected results come from plain integer division in the bench.
module tb_seq_div_16_8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] IN1 = '0;
  logic [7:0]  IN2 = '0;
  logic        in_ready, out_valid, div_by_zero;
  logic [15:0] Q;
  logic [7:0]  R;
`ifdef DIV_EXACT_CHECK_EN
  logic        check_err;
`endif

  int total = 0;
  int bad = 0;

  seq_div_16_8 dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .IN1         (IN1),
    .IN2         (IN2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .Q           (Q),
    .R           (R),
`ifdef DIV_EXACT_CHECK_EN
    .check_err   (check_err),
`endif
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [15:0] n, input logic [7:0] d, input int hold, input string tag);
    logic [15:0] eq;
    logic [7:0]  er;
    logic        ed;
    int          cyc;
    int          lat_exp;
    if (d == 8'd0) begin
      eq = 16'hFFFF; er = 8'd0; ed = 1'b1; lat_exp = 1;
    end else begin
      eq = n / d; er = n % d; ed = 1'b0; lat_exp = 17;
    end
    cyc = 0;
    while (!in_ready && cyc < 40) begin step(); cyc++; end
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; IN1 = n; IN2 = d;
    step();
    in_valid = 1'b0; IN1 = 16'($urandom); IN2 = 8'($urandom);
    cyc = 1;
    while (!out_valid && cyc < 40) begin step(); cyc++; end
    chk({tag, "_latency"}, 32'(cyc), 32'(lat_exp));
    chk({tag, "_q"}, 32'(Q), 32'(eq));
    chk({tag, "_r"}, 32'(R), 32'(er));
    chk({tag, "_dbz"}, 32'(div_by_zero), 32'(ed));
`ifdef DIV_EXACT_CHECK_EN
    chk({tag, "_check_err"}, 32'(check_err), 32'd0);
`endif
    for (int i = 0; i < hold; i++) step();
    chk({tag, "_held_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_held_busy"}, 32'(in_ready), 32'd0);
    chk({tag, "_held_q"}, 32'(Q), 32'(eq));
    chk({tag, "_held_r"}, 32'(R), 32'(er));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_drained"}, 32'(out_valid), 32'd0);
    chk({tag, "_ready_again"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] rn;
    logic [7:0]  rd;
    rst = 1'b1;
    repeat (3) step();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_q", 32'(Q), 32'd0);
    chk("rst_r", 32'(R), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready_low", 32'(in_ready), 32'd0);
    step();
    chk("rel_in_ready_high", 32'(in_ready), 32'd1);

    do_op(16'd1000, 8'd7, 0, "n1000_d7");
    do_op(16'd65535, 8'd255, 0, "n65535_d255");
    do_op(16'd3, 8'd200, 0, "n3_d200");
    do_op(16'd5, 8'd0, 0, "n5_d0");
    do_op(16'd1000, 8'd7, 10, "backpressure");

    // Abort a division eight cycles into the calculation.
    while (!in_ready) step();
    in_valid = 1'b1; IN1 = 16'd1000; IN2 = 8'd7;
    step();
    in_valid = 1'b0;
    repeat (8) step();
    rst = 1'b1;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    chk("abort_q", 32'(Q), 32'd0);
    chk("abort_r", 32'(R), 32'd0);
    chk("abort_dbz", 32'(div_by_zero), 32'd0);
    step();
    rst = 1'b0;
    do_op(16'd9, 8'd2, 0, "post_abort");

    for (int i = 0; i < 2000; i++) begin
      rn = (i % 37 == 0) ? 16'd0 : 16'($urandom_range(0, 65535));
      case (i % 50)
        0:       rd = 8'd1;
        1:       rd = 8'd255;
        default: rd = 8'($urandom_range(0, 255));
      endcase
      do_op(rn, rd, (i % 7 == 0) ? int'($urandom_range(1, 3)) : 0, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
